// File: rtl/fifo_rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_adapter
//
// Read-side companion to the async FIFO. It issues read strobes to the FIFO,
// whose registered rd_data returns one cycle after an accepted strobe. It then
// presents the words as a first-word-fall-through valid/ready stream in the
// read clock domain.
//
// A 2-entry skid buffer (head/tail) lets the stream move one word per cycle
// while still absorbing back-pressure. m_data is always the head register, so
// there is no combinational path from fifo_rd_data to m_data.
//
// Ports:
//   rd_clk         read-domain clock (only clock)
//   rd_rst         synchronous, active-high reset
//   fifo_rd_en     read strobe to the FIFO
//   fifo_rd_data   FIFO read data, valid the cycle after an accepted strobe
//   fifo_rd_empty  FIFO empty flag
//   flush          discard all buffered and in-flight words
//   m_valid        stream word available
//   m_ready        downstream accepts
//   m_data         stream data (head of the skid buffer)
//   occupancy      words held in the skid buffer (0..2)
//   word_cnt       completed m_valid && m_ready transfers, wrapping
// -----------------------------------------------------------------------------
module fifo_rd_stream_adapter #(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 32
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  output logic                fifo_rd_en,
  input  logic [BITS-1:0]     fifo_rd_data,
  input  logic                fifo_rd_empty,
  input  logic                flush,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [BITS-1:0]     m_data,
  output logic [1:0]          occupancy,
  output logic [CNT_BITS-1:0] word_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                state;
  occ_e                state_next;
  logic                inflight;
  logic [BITS-1:0]     head;
  logic [BITS-1:0]     head_next;
  logic [BITS-1:0]     tail;
  logic [BITS-1:0]     tail_next;
  logic [CNT_BITS-1:0] cnt;

  logic                pop;
  logic                capture;
  logic [1:0]          after_pop;
  logic [1:0]          committed;

  // ---------------------------------------------------------------------------
  // Stream side: everything presented downstream comes from registers.
  // ---------------------------------------------------------------------------
  assign occupancy = state;
  assign m_valid   = (state != EMPTY);
  assign m_data    = head;
  assign word_cnt  = cnt;
  assign pop       = m_valid && m_ready;

  // Words left in the buffer once this cycle's pop (if any) has gone.
  assign after_pop = occupancy - {1'b0, pop};

  // Slots already spoken for: buffered words plus the word still returning
  // from the FIFO, minus the word leaving this cycle. A new read is only
  // issued when that total leaves room, so the buffer can never overflow.
  // A pop implies occupancy >= 1, so the subtraction never underflows.
  assign committed = occupancy + {1'b0, inflight} - {1'b0, pop};

  assign fifo_rd_en = !rd_rst && !flush && !fifo_rd_empty && (committed < 2'd2);

  // The FIFO's output register only holds a fresh word the cycle after an
  // accepted read; otherwise it holds stale data and must be ignored. A flush
  // also drops the word returning in the flush cycle.
  assign capture = inflight && !flush;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    head_next  = head;
    tail_next  = tail;

    // Pop: the second word (if any) advances to the head.
    if (pop && (state == TWO)) begin
      head_next = tail;
    end

    // Capture lands behind whatever remains after the pop, preserving order.
    if (capture) begin
      if (after_pop == 2'd0) begin
        head_next = fifo_rd_data;
      end else begin
        tail_next = fifo_rd_data;
      end
    end

    if (flush) begin
      state_next = EMPTY;
    end else if (pop && !capture) begin
      state_next = (state == TWO) ? ONE : EMPTY;
    end else if (capture && !pop) begin
      // TWO is never reached with a capture pending: the issue gate
      // reserves a slot for every in-flight word.
      state_next = (state == EMPTY) ? ONE : TWO;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      // NOTE: the two buffer entries are plain registers, not a RAM, so they
      // are cleared here to make m_data read as zero out of reset.
      state    <= EMPTY;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_next;
      // fifo_rd_en is already gated by !fifo_rd_empty, so it is exactly
      // "a read was accepted at this edge".
      inflight <= fifo_rd_en;
      head     <= head_next;
      tail     <= tail_next;
      if (pop) begin
        cnt <= cnt + CNT_BITS'(1);
      end
    end
  end

endmodule
